// File: rtl/grid_ctl.sv
// grid_ctl: owner of the 12x12 ship grid (256 x 2-bit cells, address {x, y}).
// A single FSM serialises grid clears, ship placements and shots through the
// one write port; a second synchronous read port serves the display.
// Cell codes: 00 EMPTY, 01 MYSHIP, 10 MISS, 11 HIT.
// Optional feature: define GRID_CTL_SHIP_LIMIT_EN to cap placements at
// MAX_SHIP_CELLS surviving ship cells. Without it the only cap is 255.
module grid_ctl #(
  parameter int MAX_SHIP_CELLS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rd_addr,
  output logic [1:0] rd_data,
  input  logic       place_req,
  input  logic [3:0] place_x,
  input  logic [3:0] place_y,
  output logic       place_ack,
  output logic       place_ok,
  input  logic       shot_req,
  input  logic [3:0] shot_x,
  input  logic [3:0] shot_y,
  output logic       shot_done,
  output logic [1:0] shot_result,
  input  logic       clear_req,
  output logic       busy,
  output logic [7:0] ship_cells,
  output logic       all_sunk
);

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_MISS  = 2'b10;
  localparam logic [1:0] CELL_HIT   = 2'b11;

`ifdef GRID_CTL_SHIP_LIMIT_EN
  localparam logic [7:0] SHIP_LIMIT = (MAX_SHIP_CELLS > 255) ? 8'hFF : 8'(MAX_SHIP_CELLS);
`else
  localparam logic [7:0] SHIP_LIMIT = 8'hFF;
  // The limit parameter has no effect in this build; keep it visibly consumed.
  localparam int unused_max_ship_cells = MAX_SHIP_CELLS;
`endif

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    PLACE_RD,
    PLACE_WR,
    SHOT_RD,
    SHOT_WR
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] clr_cnt;
  logic [3:0] req_x;
  logic [3:0] req_y;
  logic [7:0] req_addr;
  logic [1:0] cell_q;
  logic [1:0] mem [256];

  logic       in_range;
  logic       full;
  logic       accept_clear;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [1:0] mem_wdata;
  logic       ack_d;
  logic       ok_d;
  logic       done_d;
  logic [1:0] result_d;
  logic       inc;
  logic       dec;

  assign req_addr     = {req_x, req_y};
  assign in_range     = (req_x < 4'd12) && (req_y < 4'd12);
  assign full         = (ship_cells == SHIP_LIMIT) || (ship_cells == 8'hFF);
  assign accept_clear = (state == IDLE) && clear_req;

  // State register; reset restarts the full clear sweep.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= next_state;
  end

  // Next-state logic; requests are only looked at in IDLE, clear has priority.
  // NOTE: next_state gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR:    if (clr_cnt == 8'd255) next_state = IDLE;
      IDLE: begin
        if (clear_req)      next_state = CLEAR;
        else if (shot_req)  next_state = SHOT_RD;
        else if (place_req) next_state = PLACE_RD;
      end
      PLACE_RD: next_state = PLACE_WR;
      PLACE_WR: next_state = IDLE;
      SHOT_RD:  next_state = SHOT_WR;
      SHOT_WR:  next_state = IDLE;
      default:  next_state = CLEAR;
    endcase
  end

  // Output/decision logic: write-port control and next values of the responses.
  always_comb begin
    busy      = (state != IDLE);
    mem_we    = 1'b0;
    mem_waddr = req_addr;
    mem_wdata = CELL_EMPTY;
    ack_d     = 1'b0;
    ok_d      = 1'b0;
    done_d    = 1'b0;
    result_d  = 2'b00;
    inc       = 1'b0;
    dec       = 1'b0;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
      end
      PLACE_WR: begin
        ack_d = 1'b1;
        if (in_range && (cell_q == CELL_EMPTY) && !full) begin
          ok_d      = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = CELL_SHIP;
          inc       = 1'b1;
        end
      end
      SHOT_WR: begin
        done_d = 1'b1;
        if (in_range) begin
          case (cell_q)
            CELL_EMPTY: begin
              mem_we    = 1'b1;
              mem_wdata = CELL_MISS;
              result_d  = CELL_MISS;
            end
            CELL_SHIP: begin
              mem_we    = 1'b1;
              mem_wdata = CELL_HIT;
              result_d  = CELL_HIT;
              dec       = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Clear sweep address; restarts from 0 on reset or an accepted clear.
  always_ff @(posedge clk) begin
    if (rst || accept_clear) clr_cnt <= 8'd0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + 8'd1;
  end

  // Request coordinates are captured on the accepting edge.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (shot_req) begin
        req_x <= shot_x;
        req_y <= shot_y;
      end else begin
        req_x <= place_x;
        req_y <= place_y;
      end
    end
  end

  // Surviving ship count and sunk flag, zeroed on entry to a clear.
  always_ff @(posedge clk) begin
    if (rst || accept_clear) begin
      ship_cells <= 8'd0;
      all_sunk   <= 1'b0;
    end else if (inc) begin
      ship_cells <= ship_cells + 8'd1;
    end else if (dec && (ship_cells != 8'd0)) begin
      ship_cells <= ship_cells - 8'd1;
      if (ship_cells == 8'd1) all_sunk <= 1'b1;
    end
  end

  // Registered request responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      place_ack   <= 1'b0;
      place_ok    <= 1'b0;
      shot_done   <= 1'b0;
      shot_result <= 2'b00;
    end else begin
      place_ack   <= ack_d;
      place_ok    <= ok_d;
      shot_done   <= done_d;
      shot_result <= result_d;
    end
  end

  // Grid storage write port.
  // NOTE: the array has no reset so it maps onto RAM; the CLEAR sweep that
  // follows every reset is what initialises its contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Display read port, read-first against a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= 2'b00;
    else     rd_data <= mem[rd_addr];
  end

  // Internal read port feeding the RD -> WR decision.
  always_ff @(posedge clk) begin
    cell_q <= mem[req_addr];
  end

endmodule

// File: tb/tb_grid_ctl.sv
// tb_grid_ctl: directed and randomized checks of grid_ctl against a
// behavioural grid model (array of cells plus a ship counter).
module tb_grid_ctl;

  localparam int MAX_CELLS = 2;
`ifdef GRID_CTL_SHIP_LIMIT_EN
  localparam int LIMIT = MAX_CELLS;
`else
  localparam int LIMIT = 255;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rd_addr = 8'd0;
  logic [1:0] rd_data;
  logic       place_req = 1'b0;
  logic [3:0] place_x = 4'd0;
  logic [3:0] place_y = 4'd0;
  logic       place_ack;
  logic       place_ok;
  logic       shot_req = 1'b0;
  logic [3:0] shot_x = 4'd0;
  logic [3:0] shot_y = 4'd0;
  logic       shot_done;
  logic [1:0] shot_result;
  logic       clear_req = 1'b0;
  logic       busy;
  logic [7:0] ship_cells;
  logic       all_sunk;

  always #5 clk = ~clk;

  grid_ctl #(.MAX_SHIP_CELLS(MAX_CELLS)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .place_req   (place_req),
    .place_x     (place_x),
    .place_y     (place_y),
    .place_ack   (place_ack),
    .place_ok    (place_ok),
    .shot_req    (shot_req),
    .shot_x      (shot_x),
    .shot_y      (shot_y),
    .shot_done   (shot_done),
    .shot_result (shot_result),
    .clear_req   (clear_req),
    .busy        (busy),
    .ship_cells  (ship_cells),
    .all_sunk    (all_sunk)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] model_mem [256];
  int         model_ships = 0;
  logic       model_sunk  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) model_mem[i] = 2'b00;
    model_ships = 0;
    model_sunk  = 1'b0;
  endfunction

  function automatic logic model_place(input logic [3:0] x, input logic [3:0] y);
    int a;
    a = {24'd0, x, y};
    if (x < 12 && y < 12 && model_mem[a] == 2'b00 && model_ships < LIMIT && model_ships < 255) begin
      model_mem[a] = 2'b01;
      model_ships++;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] model_shot(input logic [3:0] x, input logic [3:0] y);
    int a;
    a = {24'd0, x, y};
    if (x >= 12 || y >= 12) return 2'b00;
    if (model_mem[a] == 2'b00) begin
      model_mem[a] = 2'b10;
      return 2'b10;
    end
    if (model_mem[a] == 2'b01) begin
      model_mem[a] = 2'b11;
      model_ships--;
      if (model_ships == 0) model_sunk = 1'b1;
      return 2'b11;
    end
    return 2'b00;
  endfunction

  // Called at the negedge following the edge that started a clear.
  task automatic wait_clear(input string tag);
    int n;
    int strays;
    n = 0;
    strays = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      n++;
      if (place_ack || shot_done) strays++;
      @(negedge clk);
    end
    model_clear();
    check({tag, " busy cycles"}, n, 256);
    check({tag, " stray responses"}, strays, 0);
    check({tag, " ship_cells"}, {24'd0, ship_cells}, 0);
    check({tag, " all_sunk"}, {31'd0, all_sunk}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset outputs",
          {15'd0, rd_data, place_ack, place_ok, shot_done, shot_result, busy, ship_cells, all_sunk},
          {15'd0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'd0, 1'b0});
    rst = 1'b0;
    wait_clear("reset");
  endtask

  task automatic scan(input string tag);
    for (int a = 0; a < 256; a++) begin
      rd_addr = 8'(a);
      @(posedge clk);
      #1;
      check($sformatf("%s cell %02h", tag, a), {30'd0, rd_data}, {30'd0, model_mem[a]});
      @(negedge clk);
    end
  endtask

  // Starts and ends on a negedge; the next request can follow immediately.
  task automatic do_op(input logic is_shot, input logic [3:0] x, input logic [3:0] y,
                       output logic [1:0] resp);
    logic [1:0] exp;
    int lat;
    int other;
    int busy_low;
    string tag;
    tag = $sformatf("%s(%0d,%0d)", is_shot ? "shot" : "place", x, y);
    if (is_shot) begin
      shot_req = 1'b1; shot_x = x; shot_y = y;
    end else begin
      place_req = 1'b1; place_x = x; place_y = y;
    end
    @(posedge clk);
    @(negedge clk);
    shot_req  = 1'b0;
    place_req = 1'b0;
    exp = is_shot ? model_shot(x, y) : {1'b0, model_place(x, y)};
    lat = 0; other = 0; busy_low = 0; resp = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      if (is_shot ? shot_done : place_ack) begin
        lat  = i;
        resp = is_shot ? shot_result : {1'b0, place_ok};
        break;
      end
      if (is_shot ? place_ack : shot_done) other++;
      if (!busy) busy_low++;
      @(negedge clk);
    end
    check({tag, " latency"}, lat, 3);
    check({tag, " result"}, {30'd0, resp}, {30'd0, exp});
    check({tag, " busy profile"}, {busy_low[30:0], busy}, 0);
    check({tag, " other response"}, other, 0);
    check({tag, " ship_cells"}, {24'd0, ship_cells}, model_ships);
    check({tag, " all_sunk"}, {31'd0, all_sunk}, {31'd0, model_sunk});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r;
    logic       exp_ok;
    int         acks;
    int         dones;
    logic       seen_ok;

    model_clear();
    @(negedge clk);
    do_reset();
    scan("after reset");

    // Placement and re-placement of the same cell.
    do_op(1'b0, 4'd3, 4'd5, r);
    check("first place ok", {30'd0, r}, 1);
    do_op(1'b0, 4'd3, 4'd5, r);
    check("repeat place rejected", {30'd0, r}, 0);
    rd_addr = 8'h35;
    @(posedge clk); #1;
    check("cell 35 after place", {30'd0, rd_data}, 1);
    @(negedge clk);

    // Sink the only ship, repeat the shot, then a plain miss.
    do_op(1'b1, 4'd3, 4'd5, r);
    check("hit result", {30'd0, r}, 3);
    check("all_sunk after last hit", {31'd0, all_sunk}, 1);
    do_op(1'b1, 4'd3, 4'd5, r);
    check("repeat shot rejected", {30'd0, r}, 0);
    do_op(1'b1, 4'd0, 4'd0, r);
    check("miss result", {30'd0, r}, 2);

    // Out-of-range coordinates.
    do_op(1'b0, 4'd12, 4'd4, r);
    check("place x=12 rejected", {30'd0, r}, 0);
    do_op(1'b1, 4'd4, 4'd15, r);
    check("shot y=15 rejected", {30'd0, r}, 0);
    do_op(1'b0, 4'd11, 4'd11, r);
    check("place corner (11,11) ok", {30'd0, r}, 1);
    scan("after directed");

    // A shot raised while a placement is in flight is dropped.
    place_req = 1'b1; place_x = 4'd1; place_y = 4'd1;
    @(posedge clk);
    @(negedge clk);
    place_req = 1'b0;
    shot_req = 1'b1; shot_x = 4'd11; shot_y = 4'd11;
    exp_ok = model_place(4'd1, 4'd1);
    @(posedge clk);
    @(negedge clk);
    shot_req = 1'b0;
    acks = 0; dones = 0; seen_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (place_ack) begin acks++; seen_ok = place_ok; end
      if (shot_done) dones++;
      @(negedge clk);
    end
    check("busy-drop place acks", acks, 1);
    check("busy-drop place ok", {31'd0, seen_ok}, {31'd0, exp_ok});
    check("busy-drop shot dones", dones, 0);
    check("busy-drop ship_cells", {24'd0, ship_cells}, model_ships);

`ifdef GRID_CTL_SHIP_LIMIT_EN
    // Limit: two ships already on the grid, a third valid placement fails.
    do_op(1'b0, 4'd2, 4'd2, r);
    check("limit third place rejected", {30'd0, r}, 0);
    check("limit ship_cells", {24'd0, ship_cells}, MAX_CELLS);
`endif

    // Randomized mix of placements and shots, mostly in range.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] x;
      logic [3:0] y;
      x = 4'($urandom_range(0, 13));
      y = 4'($urandom_range(0, 13));
      do_op(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, x, y, r);
    end
    scan("after random");

    // Simultaneous clear and shot on a populated grid: clear wins.
    void'(model_place(4'd6, 4'd6));
    do_op(1'b0, 4'd7, 4'd7, r);
    clear_req = 1'b1;
    shot_req  = 1'b1; shot_x = 4'd7; shot_y = 4'd7;
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    shot_req  = 1'b0;
    wait_clear("clear");
    scan("after clear");

    // Reset while a shot is in SHOT_RD: abandoned, clear restarts.
    do_op(1'b0, 4'd2, 4'd9, r);
    check("pre-reset place ok", {30'd0, r}, 1);
    shot_req = 1'b1; shot_x = 4'd2; shot_y = 4'd9;
    @(posedge clk);
    @(negedge clk);
    shot_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_clear("mid-shot reset");
    scan("after mid-shot reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
